// File: rtl/multfloat_pkg.sv
// Shared definitions for the MultFloat sharing logic.
// Contents:
//   FLOAT_W      - width of a single-precision float word
//   float_t      - single-precision float word type
//   MULT_LATENCY - default MultFloat pipeline depth in cycles
//   TAG_ID_W     - id field width; wide enough for up to 8 requesters
//   tag_t        - {valid, id} entry carried alongside each multiply
package multfloat_pkg;

  localparam int FLOAT_W      = 32;
  localparam int MULT_LATENCY = 8;
  localparam int TAG_ID_W     = 3;

  typedef logic [FLOAT_W-1:0] float_t;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/multfloat_rr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority picker.
// Picks the first set request bit, scanning upward from the pointer and
// wrapping back to bit 0.
// Ports:
//   req_i   - request vector
//   ptr_i   - highest-priority index this cycle (always < NREQ)
//   gnt_o   - one-hot grant, zero when no request is set
//   idx_o   - index of the granted requester
//   valid_o - a grant was made
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  idx_o,
  output logic            valid_o
);

  logic found;

  // The first pass covers indices at or above the pointer. The second pass
  // only matters when the first found nothing, so any hit it takes lies
  // below the pointer, which gives the wrap-around.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req_i[i] && (i >= int'(ptr_i))) begin
        found    = 1'b1;
        gnt_o[i] = 1'b1;
        idx_o    = IDW'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req_i[i]) begin
        found    = 1'b1;
        gnt_o[i] = 1'b1;
        idx_o    = IDW'(i);
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/multfloat_rr_arbiter.sv
// multfloat_rr_arbiter: shares one pipelined single-precision MultFloat among
// NREQ requesters. Accepts at most one operand pair per cycle, registers it
// onto the multiplier inputs, carries the requester id down a tag delay line
// matched to the multiplier, and steers each product back with a one-cycle
// resp_valid pulse.
// Optional build macro MULTARB_CEGATE_EN: gates mul_ce (and the local
// operand/tag registers) off when nothing is requesting or in flight.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   req          - per-requester operand valid
//   a_in, b_in   - operands, requester i in bits [32i+31:32i]
//   gnt          - one-hot combinational grant
//   resp_valid   - one-hot response pulse
//   result_out   - product belonging to the resp_valid requester
//   mul_ce       - MultFloat clock enable
//   mul_a, mul_b - registered operands to MultFloat
//   mul_result   - product from MultFloat
import multfloat_pkg::*;

module multfloat_rr_arbiter #(
  parameter int NREQ    = 4,
  parameter int LATENCY = MULT_LATENCY,
  parameter int IDW     = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*FLOAT_W-1:0] a_in,
  input  logic [NREQ*FLOAT_W-1:0] b_in,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         resp_valid,
  output logic [FLOAT_W-1:0]      result_out,
  output logic                    mul_ce,
  output logic [FLOAT_W-1:0]      mul_a,
  output logic [FLOAT_W-1:0]      mul_b,
  input  logic [FLOAT_W-1:0]      mul_result
);

  logic [IDW-1:0]  ptr_q, ptr_d;
  float_t          mul_a_q, mul_a_d;
  float_t          mul_b_q, mul_b_d;
  // Stage 0 lines up with the operand register; stages 1..LATENCY line up
  // with the MultFloat pipeline, so the tail matches mul_result.
  tag_t            tag_q [0:LATENCY];
  tag_t            tag_d [0:LATENCY];

  logic [NREQ-1:0] pick_gnt;
  logic [IDW-1:0]  pick_idx;
  logic            pick_vld;
  logic            grant_fire;
  logic            any_tag_valid;
  logic            ce;

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .valid_o (pick_vld)
  );

  // Grants are suppressed during reset so nothing is accepted on the
  // clearing edge.
  assign gnt        = rst ? '0 : pick_gnt;
  assign grant_fire = !rst && pick_vld;

  always_comb begin
    any_tag_valid = 1'b0;
    for (int j = 0; j <= LATENCY; j++) begin
      any_tag_valid = any_tag_valid | tag_q[j].valid;
    end
  end

`ifdef MULTARB_CEGATE_EN
  // Idle when nobody asks and nothing is in flight; freezing the multiplier
  // and the tag line together keeps them aligned.
  assign ce = (|req) | any_tag_valid;
`else
  assign ce = 1'b1;
`endif

  assign mul_ce = ce;

  // Next-state: operand mux, pointer advance and the tag shift.
  always_comb begin
    mul_a_d = mul_a_q;
    mul_b_d = mul_b_q;
    ptr_d   = ptr_q;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_gnt[i]) begin
        mul_a_d = a_in[i*FLOAT_W +: FLOAT_W];
        mul_b_d = b_in[i*FLOAT_W +: FLOAT_W];
      end
    end
    if (grant_fire) begin
      ptr_d = (int'(pick_idx) == NREQ-1) ? '0 : pick_idx + IDW'(1);
    end
    tag_d[0].valid = grant_fire;
    tag_d[0].id    = grant_fire ? TAG_ID_W'(pick_idx) : '0;
    for (int j = 1; j <= LATENCY; j++) begin
      tag_d[j] = tag_q[j-1];
    end
  end

  // State registers; reset wins over the clock-enable gate.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q   <= '0;
      mul_a_q <= '0;
      mul_b_q <= '0;
      for (int j = 0; j <= LATENCY; j++) begin
        tag_q[j] <= '0;
      end
    end else if (ce) begin
      ptr_q   <= ptr_d;
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
      for (int j = 0; j <= LATENCY; j++) begin
        tag_q[j] <= tag_d[j];
      end
    end
  end

  assign mul_a = mul_a_q;
  assign mul_b = mul_b_q;

  // Response decode from the tail of the tag line.
  always_comb begin
    resp_valid = '0;
    if (!rst && tag_q[LATENCY].valid) begin
      for (int i = 0; i < NREQ; i++) begin
        if (tag_q[LATENCY].id == TAG_ID_W'(i)) begin
          resp_valid[i] = 1'b1;
        end
      end
    end
  end

  assign result_out = mul_result;

endmodule

// File: tb/tb_multfloat_rr_arbiter.sv
// Testbench for multfloat_rr_arbiter with a behavioural MultFloat stand-in.
// Build with MULTARB_CEGATE_EN defined to exercise the clock-enable gating.
module tb_multfloat_rr_arbiter;

  localparam int NREQ    = 4;
  localparam int LATENCY = 8;
  localparam int IDW     = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req;
  logic [NREQ*32-1:0]   aIn;
  logic [NREQ*32-1:0]   bIn;
  logic [NREQ-1:0]      gnt;
  logic [NREQ-1:0]      respValid;
  logic [31:0]          resultOut;
  logic                 mulCe;
  logic [31:0]          mulA;
  logic [31:0]          mulB;
  logic [31:0]          mulResult;

  int checkCount = 0;
  int passCount  = 0;
  int cycleCount = 0;
  bit checkEn    = 1'b0;

  multfloat_rr_arbiter #(
    .NREQ    (NREQ),
    .LATENCY (LATENCY),
    .IDW     (IDW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .a_in       (aIn),
    .b_in       (bIn),
    .gnt        (gnt),
    .resp_valid (respValid),
    .result_out (resultOut),
    .mul_ce     (mulCe),
    .mul_a      (mulA),
    .mul_b      (mulB),
    .mul_result (mulResult)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  // Normal-number float multiply with truncation; exact for the test values.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    logic [47:0] p;
    int          e;
    logic [22:0] m;
    s = a[31] ^ b[31];
    if (a[30:0] == 31'd0 || b[30:0] == 31'd0) return {s, 31'd0};
    p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) begin
      m = p[46:24];
      e = e + 1;
    end else begin
      m = p[45:23];
    end
    return {s, e[7:0], m};
  endfunction

  // MultFloat stand-in: LATENCY register stages from mul_a/mul_b.
  logic [31:0] mulPipe [LATENCY];
  always @(posedge clk) begin
    if (mulCe) begin
      mulPipe[0] <= fmul(mulA, mulB);
      for (int j = 1; j < LATENCY; j++) mulPipe[j] <= mulPipe[j-1];
    end
  end
  assign mulResult = mulPipe[LATENCY-1];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, actual, expected, cycleCount);
    else
      passCount++;
  endtask

  // Scoreboard model: round-robin pointer as an integer plus a queue of
  // responses owed, each stamped with the cycle it must appear in.
  typedef struct {
    int          due;
    int          id;
    logic [31:0] val;
  } resp_t;

  resp_t       owed[$];
  int          modelPtr = 0;
  int          grantId;
  logic [3:0]  expGnt;
  logic [3:0]  expResp;
  logic [31:0] expVal;
  logic        expCe;

  always @(negedge clk) begin
    if (checkEn) begin
      expGnt  = '0;
      grantId = -1;
      if (!rst) begin
        for (int off = 0; off < NREQ; off++) begin
          if (grantId < 0 && req[(modelPtr + off) % NREQ]) grantId = (modelPtr + off) % NREQ;
        end
        if (grantId >= 0) expGnt[grantId] = 1'b1;
      end
`ifdef MULTARB_CEGATE_EN
      expCe = (req != '0) || (owed.size() > 0);
`else
      expCe = 1'b1;
`endif
      checkOutput("modelCe", {31'd0, mulCe}, {31'd0, expCe});
      checkOutput("modelGnt", {28'd0, gnt}, {28'd0, expGnt});
      expResp = '0;
      expVal  = '0;
      if (owed.size() > 0 && owed[0].due == cycleCount) begin
        if (!rst) begin
          expResp[owed[0].id] = 1'b1;
          expVal = owed[0].val;
        end
        void'(owed.pop_front());
      end
      checkOutput("modelResp", {28'd0, respValid}, {28'd0, expResp});
      if (expResp != '0) checkOutput("modelResult", resultOut, expVal);
      if (rst) begin
        owed.delete();
        modelPtr = 0;
      end else if (grantId >= 0) begin
        owed.push_back('{cycleCount + 1 + LATENCY, grantId,
                         fmul(aIn[grantId*32 +: 32], bIn[grantId*32 +: 32])});
        modelPtr = (grantId + 1) % NREQ;
      end
    end
  end

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] r, input int slot,
                               input logic [31:0] a, input logic [31:0] b);
    req = r;
    if (slot >= 0) begin
      aIn[slot*32 +: 32] = a;
      bIn[slot*32 +: 32] = b;
    end
  endtask

  task automatic doReset(input int cycles);
    rst = 1'b1;
    req = '0;
    repeat (cycles) stepCycle();
    rst = 1'b0;
  endtask

  // Collects up to n response pulses, recording mask, value and the number
  // of negedges since the previous pulse (or since the call).
  logic [3:0]  gotMask [16];
  logic [31:0] gotVal  [16];
  int          gotGap  [16];

  task automatic collectResp(input int n, input int budget);
    int gap;
    for (int k = 0; k < n; k++) begin
      gap = 0;
      gotMask[k] = '0;
      gotVal[k]  = '0;
      gotGap[k]  = -1;
      while (gap < budget) begin
        @(negedge clk);
        gap++;
        if (respValid != '0) begin
          gotMask[k] = respValid;
          gotVal[k]  = resultOut;
          gotGap[k]  = gap;
          break;
        end
      end
      if (gotGap[k] < 0) begin
        checkCount++;
        $display("[TB] FAIL respTimeout: got none, expected response %0d within %0d cycles", k, budget);
      end
    end
  endtask

  logic [3:0]  expSeq  [8];
  logic [31:0] expVals [8];
  logic [3:0]  seenGnt [8];
  int          quiet;

  initial begin
    rst = 1'b1;
    req = '0;
    aIn = '0;
    bIn = '0;
    stepCycle();
    checkEn = 1'b1;

    // Reset behaviour: no grant while rst is high even with requests.
    req = 4'hF;
    @(negedge clk);
    checkOutput("gntInReset", {28'd0, gnt}, 32'd0);
    doReset(2);
    @(negedge clk);
    checkOutput("rstMulA", mulA, 32'd0);
    checkOutput("rstMulB", mulB, 32'd0);
    checkOutput("rstResp", {28'd0, respValid}, 32'd0);
    stepCycle();

    // Single op: 2.0 * 3.0 from requester 0.
    applyStimulus(4'b0001, 0, 32'h40000000, 32'h40400000);
    @(negedge clk);
    checkOutput("singleGnt", {28'd0, gnt}, 32'h1);
    stepCycle();
    applyStimulus(4'b0000, -1, '0, '0);
    collectResp(1, 20);
    checkOutput("singleLat", gotGap[0], 32'd9);
    checkOutput("singleMask", {28'd0, gotMask[0]}, 32'h1);
    checkOutput("singleVal", gotVal[0], 32'h40C00000);
    repeat (3) stepCycle();

    // Fairness: all four held for 8 cycles from a fresh pointer.
    doReset(1);
    for (int i = 0; i < NREQ; i++) begin
      aIn[i*32 +: 32] = 32'h3F800000 + (i == 0 ? 32'h0 : 32'h00800000 * ((i == 1) ? 1 : 0))
                        + ((i == 2) ? 32'h00C00000 : 32'h0) + ((i == 3) ? 32'h01000000 : 32'h0);
      bIn[i*32 +: 32] = 32'h40000000;
    end
    expSeq  = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8};
    expVals = '{32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000,
                32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000};
    req = 4'hF;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      seenGnt[k] = gnt;
      stepCycle();
    end
    req = '0;
    for (int k = 0; k < 8; k++) checkOutput($sformatf("fairGnt%0d", k), {28'd0, seenGnt[k]}, {28'd0, expSeq[k]});
    collectResp(8, 20);
    for (int k = 0; k < 8; k++) begin
      checkOutput($sformatf("fairMask%0d", k), {28'd0, gotMask[k]}, {28'd0, expSeq[k]});
      checkOutput($sformatf("fairVal%0d", k), gotVal[k], expVals[k]);
      if (k > 0) checkOutput($sformatf("fairGap%0d", k), gotGap[k], 32'd1);
    end
    repeat (3) stepCycle();

    // Back-to-back from requester 2: (1.5*n) * 2.0, n = 1..5.
    expVals[0] = 32'h40400000;
    expVals[1] = 32'h40C00000;
    expVals[2] = 32'h41100000;
    expVals[3] = 32'h41400000;
    expVals[4] = 32'h41700000;
    seenGnt[0] = '0;
    for (int n = 0; n < 5; n++) begin
      case (n)
        0: applyStimulus(4'b0100, 2, 32'h3FC00000, 32'h40000000);
        1: applyStimulus(4'b0100, 2, 32'h40400000, 32'h40000000);
        2: applyStimulus(4'b0100, 2, 32'h40900000, 32'h40000000);
        3: applyStimulus(4'b0100, 2, 32'h40C00000, 32'h40000000);
        default: applyStimulus(4'b0100, 2, 32'h40F00000, 32'h40000000);
      endcase
      @(negedge clk);
      checkOutput($sformatf("b2bGnt%0d", n), {28'd0, gnt}, 32'h4);
      stepCycle();
    end
    req = '0;
    collectResp(5, 20);
    for (int k = 0; k < 5; k++) begin
      checkOutput($sformatf("b2bMask%0d", k), {28'd0, gotMask[k]}, 32'h4);
      checkOutput($sformatf("b2bVal%0d", k), gotVal[k], expVals[k]);
    end
    repeat (3) stepCycle();

    // Reset mid-flight: three ops from requester 1, reset 4 cycles later.
    applyStimulus(4'b0010, 1, 32'h40000000, 32'h40000000);
    repeat (3) stepCycle();
    req = '0;
    repeat (4) stepCycle();
    rst = 1'b1;
    stepCycle();
    rst = 1'b0;
    quiet = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (respValid != '0) quiet++;
    end
    checkOutput("rstDropped", quiet, 32'd0);
    stepCycle();
    // Pointer must be back at 0: with 1 and 3 asking, 1 wins.
    applyStimulus(4'b1010, 3, 32'h40000000, 32'h40400000);
    @(negedge clk);
    checkOutput("rstPtrGnt", {28'd0, gnt}, 32'h2);
    stepCycle();
    req = 4'b1000;
    @(negedge clk);
    checkOutput("rstReq3Gnt", {28'd0, gnt}, 32'h8);
    stepCycle();
    req = '0;
    collectResp(2, 20);
    checkOutput("rstRespA", {28'd0, gotMask[0]}, 32'h2);
    checkOutput("rstRespB", {28'd0, gotMask[1]}, 32'h8);
    checkOutput("rstRespBVal", gotVal[1], 32'h40C00000);
    repeat (3) stepCycle();

    // Pointer wrap: 3 granted, then 0 and 3 together -> 0 first, then 3.
    applyStimulus(4'b1000, 0, 32'h3F800000, 32'h40800000);
    @(negedge clk);
    checkOutput("wrapGnt3", {28'd0, gnt}, 32'h8);
    stepCycle();
    req = 4'b1001;
    @(negedge clk);
    checkOutput("wrapGnt0", {28'd0, gnt}, 32'h1);
    stepCycle();
    req = 4'b1000;
    @(negedge clk);
    checkOutput("wrapGnt3b", {28'd0, gnt}, 32'h8);
    stepCycle();
    req = '0;
    collectResp(3, 20);
    checkOutput("wrapResp0", {28'd0, gotMask[1]}, 32'h1);
    checkOutput("wrapVal0", gotVal[1], 32'h40800000);
    repeat (12) stepCycle();

    // Idle clock enable.
    @(negedge clk);
`ifdef MULTARB_CEGATE_EN
    checkOutput("idleCe", {31'd0, mulCe}, 32'd0);
`else
    checkOutput("idleCe", {31'd0, mulCe}, 32'd1);
`endif
    checkOutput("idleResp", {28'd0, respValid}, 32'd0);
    stepCycle();
    checkOutput("modelDrained", owed.size(), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
